// File: rtl/mux2_arb.sv
// mux2_arb: two-requester burst arbiter feeding a registered output mux.
// Alternates owners on contention; each grant is capped at MAX_BURST beats.
module mux2_arb #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              req_1,
    input  logic [DATA_W-1:0] data_1,
    input  logic              req_2,
    input  logic [DATA_W-1:0] data_2,
    output logic              gnt_1,
    output logic              gnt_2,
    output logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t     state;
    state_t     nxt;
    logic       take;
    logic [7:0] cnt;
    logic [1:0] last;
    logic       beat;
    logic       own_req;
    logic       oth_req;
    logic       burst_end;

    // A beat moves whenever the current owner is still requesting.
    always_comb begin
        beat    = (gnt_1 & req_1) | (gnt_2 & req_2);
        own_req = 1'b0;
        oth_req = 1'b0;
        case (state)
            OWN1: begin
                own_req = req_1;
                oth_req = req_2;
            end
            OWN2: begin
                own_req = req_2;
                oth_req = req_1;
            end
            default: begin
                own_req = 1'b0;
                oth_req = 1'b0;
            end
        endcase
        burst_end = ~own_req | (beat & (cnt == LAST_BEAT));
    end

    // Next owner: contention goes to whoever was not granted last;
    // at burst end the waiting side wins, else the owner re-enters.
    always_comb begin
        nxt  = state;
        take = 1'b0;
        case (state)
            IDLE: begin
                if (req_1 && (!req_2 || last == 2'd2)) begin
                    nxt  = OWN1;
                    take = 1'b1;
                end else if (req_2) begin
                    nxt  = OWN2;
                    take = 1'b1;
                end
            end
            OWN1, OWN2: begin
                if (burst_end) begin
                    if (oth_req) begin
                        nxt  = (state == OWN1) ? OWN2 : OWN1;
                        take = 1'b1;
                    end else if (own_req) begin
                        nxt  = state;
                        take = 1'b1;
                    end else begin
                        nxt  = IDLE;
                        take = 1'b0;
                    end
                end
            end
            default: begin
                nxt  = IDLE;
                take = 1'b0;
            end
        endcase
    end

    // Grant FSM with registered grant, select and busy outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            gnt_1 <= 1'b0;
            gnt_2 <= 1'b0;
            sel   <= 1'b1;
            busy  <= 1'b0;
            cnt   <= 8'd0;
            last  <= 2'd2;
        end else begin
            state <= nxt;
            gnt_1 <= (nxt == OWN1);
            gnt_2 <= (nxt == OWN2);
            busy  <= (nxt != IDLE);
            if (nxt == OWN1) begin
                sel <= 1'b1;
            end else if (nxt == OWN2) begin
                sel <= 1'b0;
            end
            if (take) begin
                cnt  <= 8'd0;
                last <= (nxt == OWN1) ? 2'd1 : 2'd2;
            end else if (beat) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Output register captures the selected path on each beat.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= beat;
            if (beat) begin
                out_data <= sel ? data_1 : data_2;
            end
        end
    end

endmodule

// File: tb/tb_mux2_arb.sv
// tb_mux2_arb: directed and random checks of mux2_arb at burst limits 16, 4 and 1.
// Expected beats are queued by a reference model and popped by a monitor.
module tb_mux2_arb;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       req_1  = 1'b0;
    logic       req_2  = 1'b0;
    logic [7:0] data_1 = 8'h00;
    logic [7:0] data_2 = 8'h00;

    logic       g1[3];
    logic       g2[3];
    logic       sl[3];
    logic       ov[3];
    logic       bz[3];
    logic [7:0] od[3];

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [1:0] s;
        logic [7:0] c;
        logic [1:0] l;
        logic       sel;
    } mst_t;

    localparam mst_t MRST = '{s: 2'd0, c: 8'd0, l: 2'd2, sel: 1'b1};

    mst_t       m[3];
    logic [7:0] exq[3][$];

    always #5 clk = ~clk;

    mux2_arb #(.DATA_W(8), .MAX_BURST(16)) u16 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req_1(req_1), .data_1(data_1),
        .req_2(req_2), .data_2(data_2),
        .gnt_1(g1[0]), .gnt_2(g2[0]), .sel(sl[0]),
        .out_data(od[0]), .out_valid(ov[0]), .busy(bz[0])
    );

    mux2_arb #(.DATA_W(8), .MAX_BURST(4)) u4 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req_1(req_1), .data_1(data_1),
        .req_2(req_2), .data_2(data_2),
        .gnt_1(g1[1]), .gnt_2(g2[1]), .sel(sl[1]),
        .out_data(od[1]), .out_valid(ov[1]), .busy(bz[1])
    );

    mux2_arb #(.DATA_W(8), .MAX_BURST(1)) u1 (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req_1(req_1), .data_1(data_1),
        .req_2(req_2), .data_2(data_2),
        .gnt_1(g1[2]), .gnt_2(g2[2]), .sel(sl[2]),
        .out_data(od[2]), .out_valid(ov[2]), .busy(bz[2])
    );

    function automatic int maxb(input int k);
        return (k == 0) ? 16 : ((k == 1) ? 4 : 1);
    endfunction

    function automatic mst_t mstep(input mst_t cur, input logic r1,
                                   input logic r2, input int mb);
        mst_t n;
        logic own;
        logic oth;
        logic enter;
        n     = cur;
        enter = 1'b0;
        own   = (cur.s == 2'd1) ? r1 : ((cur.s == 2'd2) ? r2 : 1'b0);
        oth   = (cur.s == 2'd1) ? r2 : ((cur.s == 2'd2) ? r1 : 1'b0);
        if (cur.s == 2'd0) begin
            if (r1 && r2) n.s = (cur.l == 2'd1) ? 2'd2 : 2'd1;
            else if (r1) n.s = 2'd1;
            else if (r2) n.s = 2'd2;
            enter = (n.s != 2'd0);
        end else if (!own || int'(cur.c) == mb - 1) begin
            n.s   = oth ? (2'd3 - cur.s) : (own ? cur.s : 2'd0);
            enter = (n.s != 2'd0);
        end else begin
            n.c = cur.c + 8'd1;
        end
        if (enter) begin
            n.c   = 8'd0;
            n.l   = n.s;
            n.sel = (n.s == 2'd1);
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: queues the data of every beat it predicts.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m[k] <= MRST;
                exq[k].delete();
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if ((m[k].s == 2'd1 && req_1) || (m[k].s == 2'd2 && req_2))
                    exq[k].push_back((m[k].s == 2'd1) ? data_1 : data_2);
                m[k] <= mstep(m[k], req_1, req_2, maxb(k));
            end
        end
    end

    // Monitor: compares grants and pops expected beats on out_valid.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mon gnt_1 u%0d", k), g1[k], m[k].s == 2'd1);
            chk($sformatf("mon gnt_2 u%0d", k), g2[k], m[k].s == 2'd2);
            chk($sformatf("mon busy u%0d", k), bz[k], m[k].s != 2'd0);
            chk($sformatf("mon sel u%0d", k), sl[k], m[k].sel);
            chk($sformatf("mon mutex u%0d", k), g1[k] & g2[k], 0);
            chk($sformatf("mon out_valid u%0d", k), ov[k],
                exq[k].size() != 0);
            if (ov[k] && exq[k].size() != 0)
                chk($sformatf("mon out_data u%0d", k), od[k],
                    exq[k].pop_front());
        end
    end

    initial begin
        tick(2);
        chk("rst gnt_1", g1[0], 0);
        chk("rst gnt_2", g2[0], 0);
        chk("rst sel", sl[0], 1);
        chk("rst out_valid", ov[0], 0);
        chk("rst out_data", od[0], 0);
        chk("rst busy", bz[0], 0);
        chk("rst cnt", u16.cnt, 0);
        chk("rst last", u16.last, 2);
        rst_n = 1'b1;
        tick(1);

        // single requester, five beats
        req_1  = 1'b1;
        data_1 = 8'h11;
        chk("A gnt before", g1[0], 0);
        tick(1);
        chk("A gnt", g1[0], 1);
        chk("A idle no beat", ov[0], 0);
        for (int i = 0; i < 5; i++) begin
            data_1 = 8'h11 + 8'(i);
            tick(1);
            chk("A valid", ov[0], 1);
            chk("A data", od[0], 'h11 + i);
        end
        req_1 = 1'b0;
        tick(1);
        chk("A busy end", bz[0], 0);
        chk("A gnt end", g1[0], 0);
        chk("A valid end", ov[0], 0);

        // both requesters straight after reset
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        req_1 = 1'b1;
        req_2 = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            data_1 = 8'hA0 + 8'(k);
            data_2 = 8'hC0 + 8'(k);
            tick(1);
            chk("B burst1 alternate", g1[2], k % 2);
            if (k == 1 || k == 16 || k == 33) chk("B gnt_1", g1[0], 1);
            if (k == 17 || k == 32) chk("B gnt_2", g2[0], 1);
            if (k >= 2 && k <= 17) chk("B data_1", od[0], 'hA0 + k);
            if (k >= 18) chk("B data_2", od[0], 'hC0 + k);
        end
        req_1 = 1'b0;
        req_2 = 1'b0;
        tick(2);

        // lone requester at burst limit 4
        req_2  = 1'b1;
        data_2 = 8'h40;
        tick(1);
        chk("C gnt", g2[1], 1);
        for (int i = 0; i < 10; i++) begin
            data_2 = 8'h40 + 8'(i);
            tick(1);
            chk("C gnt hold", g2[1], 1);
            chk("C valid", ov[1], 1);
            chk("C data", od[1], 'h40 + i);
            chk("C cnt", u4.cnt, (i + 1) % 4);
        end
        req_2 = 1'b0;
        tick(1);
        chk("C idle", bz[1], 0);
        chk("C valid end", ov[1], 0);

        // no pre-emption of requester 2
        req_2  = 1'b1;
        data_2 = 8'h70;
        tick(1);
        chk("D gnt_2", g2[0], 1);
        tick(1);
        req_1  = 1'b1;
        data_1 = 8'h90;
        tick(2);
        chk("D hold gnt_2", g2[0], 1);
        chk("D no gnt_1", g1[0], 0);
        chk("D sel before", sl[0], 0);
        req_2 = 1'b0;
        tick(1);
        chk("D gnt_1", g1[0], 1);
        chk("D gnt_2 off", g2[0], 0);
        chk("D sel after", sl[0], 1);
        req_1 = 1'b0;
        tick(2);

        // reset during beat 3 of an OWN1 burst
        req_1  = 1'b1;
        data_1 = 8'h31;
        tick(1);
        chk("E gnt_1", g1[0], 1);
        tick(2);
        rst_n = 1'b0;
        req_2 = 1'b1;
        #1;
        chk("E gnt_1 drop", g1[0], 0);
        chk("E gnt_2 drop", g2[0], 0);
        chk("E valid drop", ov[0], 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("E regrant 1", g1[0], 1);
        chk("E regrant 2", g2[0], 0);
        req_1 = 1'b0;
        req_2 = 1'b0;
        tick(2);

        // random request patterns
        for (int i = 0; i < 10000; i++) begin
            req_1  = ($urandom_range(0, 3) != 0);
            req_2  = ($urandom_range(0, 3) != 0);
            data_1 = 8'($urandom);
            data_2 = 8'($urandom);
            tick(1);
        end
        req_1 = 1'b0;
        req_2 = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
